// File: rtl/xgmii_fifo_unpacker_pkg.sv
// Shared XGMII constants and the 36-bit {ctrl,data} half-word type used by the FIFO unpacker.
package xgmii_fifo_unpacker_pkg;

  localparam int unsigned LaneWidth  = 8;
  localparam int unsigned HalfLanes  = 4;
  localparam int unsigned WordLanes  = 8;
  localparam int unsigned HalfWidth  = HalfLanes * (LaneWidth + 1);
  localparam int unsigned DataWidth  = WordLanes * LaneWidth;
  localparam int unsigned CtrlWidth  = WordLanes;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;

  localparam logic [DataWidth-1:0] IDLE_WORD64 = {WordLanes{XGMII_IDLE}};
  localparam logic [CtrlWidth-1:0] IDLE_CTRL8  = {CtrlWidth{1'b1}};

  typedef struct packed {
    logic [HalfLanes-1:0]           ctrl;
    logic [HalfLanes*LaneWidth-1:0] data;
  } half_word_t;

  // First-popped half occupies lanes 0-3, second lanes 4-7; result is {ctrl, data}.
  function automatic logic [CtrlWidth+DataWidth-1:0] pair_halves(half_word_t lo, half_word_t hi);
    return {hi.ctrl, lo.ctrl, hi.data, lo.data};
  endfunction

endpackage

// File: rtl/xgmii_fifo_unpacker.sv
// Pops 36-bit XGMII half-words from a sync FIFO and pairs them into 64-bit data / 8-bit ctrl words.
// Optional build macro XGMII_IDLE_FILL_EN presents idle words whenever nothing is pending.
module xgmii_fifo_unpacker
  import xgmii_fifo_unpacker_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 36,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [IN_WIDTH-1:0]  fifo_rd_data,
  output logic [63:0]          out_data,
  output logic [7:0]           out_ctrl,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 half_stall,
  output logic [CNT_WIDTH-1:0] word_cnt
);

  logic [1:0]           half_cnt_q, half_cnt_d;
  logic [1:0]           pend_cnt_q, pend_cnt_d;
  half_word_t           lo_q, lo_d, hi_q, hi_d;
  logic [63:0]          out_data_q, out_data_d;
  logic [7:0]           out_ctrl_q, out_ctrl_d;
  logic                 out_valid_q, out_valid_d;
  logic                 half_stall_q, half_stall_d;
  logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;

  half_word_t rd_half;
  logic       arrive;
  logic       out_free;

  assign rd_half  = half_word_t'(fifo_rd_data[HalfWidth-1:0]);
  assign arrive   = (pend_cnt_q != 2'd0);
  assign out_free = !out_valid_q || out_ready;

  assign fifo_rd_en = !rst && !fifo_empty &&
                      (({1'b0, half_cnt_q} + {1'b0, pend_cnt_q}) < 3'd2);

  always_comb begin
    half_cnt_d   = half_cnt_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    out_data_d   = out_data_q;
    out_ctrl_d   = out_ctrl_q;
    out_valid_d  = out_valid_q;
    word_cnt_d   = word_cnt_q;
    pend_cnt_d   = {1'b0, fifo_rd_en};
    half_stall_d = (half_cnt_q == 2'd1) && !arrive && fifo_empty;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      word_cnt_d  = word_cnt_q + CNT_WIDTH'(1);
    end

    case (half_cnt_q)
      2'd2: begin
        if (out_free) begin
          {out_ctrl_d, out_data_d} = pair_halves(lo_q, hi_q);
          out_valid_d = 1'b1;
          half_cnt_d  = 2'd0;
        end
      end
      2'd1: begin
        // The arriving high half goes straight to the output when the register is free.
        if (arrive) begin
          if (out_free) begin
            {out_ctrl_d, out_data_d} = pair_halves(lo_q, rd_half);
            out_valid_d = 1'b1;
            half_cnt_d  = 2'd0;
          end else begin
            hi_d       = rd_half;
            half_cnt_d = 2'd2;
          end
        end
      end
      default: begin
        if (arrive) begin
          lo_d       = rd_half;
          half_cnt_d = 2'd1;
        end
      end
    endcase

`ifdef XGMII_IDLE_FILL_EN
    if ((half_cnt_q == 2'd0) && !arrive && fifo_empty && out_free) begin
      out_data_d  = IDLE_WORD64;
      out_ctrl_d  = IDLE_CTRL8;
      out_valid_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      half_cnt_q   <= 2'd0;
      pend_cnt_q   <= 2'd0;
      lo_q         <= '0;
      hi_q         <= '0;
      out_data_q   <= '0;
      out_ctrl_q   <= '0;
      out_valid_q  <= 1'b0;
      half_stall_q <= 1'b0;
      word_cnt_q   <= '0;
    end else begin
      half_cnt_q   <= half_cnt_d;
      pend_cnt_q   <= pend_cnt_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      out_data_q   <= out_data_d;
      out_ctrl_q   <= out_ctrl_d;
      out_valid_q  <= out_valid_d;
      half_stall_q <= half_stall_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_ctrl   = out_ctrl_q;
  assign out_valid  = out_valid_q;
  assign half_stall = half_stall_q;
  assign word_cnt   = word_cnt_q;

endmodule
